// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL bring-up supervisor.
//   - sup_state_t : supervisor state encoding (3-bit)
//   - DEF_*       : default timing constants for a 10 MHz reference clock
//   - LOST_CNT_W  : width of the saturating lock-loss counter
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 1000;  // 100 us at 10 MHz
    localparam int DEF_STABLE_CYCLES = 64;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    localparam int LOST_CNT_W = 8;

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// sync_2ff
//   Two-flop single-bit synchroniser with synchronous active-high reset.
//   Also used by pixel-clock-domain consumers to resynchronise sys_reset.
//   Ports:
//     clk - destination-domain clock
//     rst - synchronous active-high reset (loads RST_VAL into both flops)
//     d   - asynchronous input
//     q   - synchronised output, two clk cycles of latency
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            // p0: first capture of the asynchronous input, may be metastable
            sync_p0 <= d;
            // p1: resolved copy handed to the destination logic
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor
//   Sequences bring-up of the PLL generating the VGA pixel clock. Holds the
//   PLL in reset, waits for a qualified lock, then releases sys_reset for the
//   pixel-clock domain. Lock loss while running restarts the PLL; repeated
//   lock timeouts park the block in a sticky fault state.
//   Ports:
//     clock_in        - 10 MHz reference clock (only clock of this block)
//     reset           - synchronous active-high reset
//     pll_locked      - raw PLL LOCK, asynchronous to clock_in
//     pll_resetb      - PLL RESETB drive, 0 holds the PLL in reset
//     sys_reset       - active-high reset for downstream logic
//     ready           - 1 while the PLL is qualified and running
//     fault           - 1 once retries are exhausted, sticky until reset
//     lock_lost_count - saturating count of lock losses seen in RUN
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  pll_resetb,
    output logic                  sys_reset,
    output logic                  ready,
    output logic                  fault,
    output logic [LOST_CNT_W-1:0] lock_lost_count
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
        return (v == {LOST_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    sup_state_t         state;
    sup_state_t         state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [RETRY_W-1:0] retry_cnt;
    logic               lock_s;
    logic               retry_inc;
    logic               retry_clr;
    logic               lost_inc;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        lost_inc  = 1'b0;
        case (state)
            PLL_RST: begin
                if (counter == RST_LAST)
                    state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (counter == TMO_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = PLL_RST;
                        retry_inc = 1'b1;
                    end
                end
            end
            STABLE: begin
                // A glitch sends us back to waiting without touching the
                // retry budget; the PLL itself is not reset.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (counter == STB_LAST) begin
                    state_nxt = RUN;
                    retry_clr = 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    lost_inc  = 1'b1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = PLL_RST;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state           <= PLL_RST;
            counter         <= '0;
            retry_cnt       <= '0;
            lock_lost_count <= '0;
            pll_resetb      <= 1'b0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state <= state_nxt;

            // Counter restarts on every state change so each state times
            // itself from entry.
            if (state_nxt != state)
                counter <= '0;
            else
                counter <= counter + 1'b1;

            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 1'b1;

            if (lost_inc)
                lock_lost_count <= sat_inc(lock_lost_count);

            // Outputs decode the next state so they switch on the same edge
            // as the state register.
            pll_resetb <= !((state_nxt == PLL_RST) || (state_nxt == FAULT));
            sys_reset  <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            fault      <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor
//   Directed, table-driven bench for pll_supervisor with
//   RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
//   Each record drives reset/pll_locked for n edges, then compares every
//   output against the hand-computed values. Edge 0 is the last edge that
//   samples reset high; an input set "at cycle k" is applied before edge k.
module tb_pll_supervisor;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] lock_lost_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        int         n;
        logic       rst;
        logic       lk;
        logic       rb;
        logic       sr;
        logic       rdy;
        logic       flt;
        logic [7:0] llc;
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];

    pll_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (16)
    ) dut (
        .clock_in        (clock_in),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_resetb      (pll_resetb),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .fault           (fault),
        .lock_lost_count (lock_lost_count)
    );

    always #50 clock_in = ~clock_in;

    function automatic vec_t mk(string nm, int n, logic rst, logic lk, logic rb,
                                logic sr, logic rdy, logic flt, logic [7:0] llc);
        vec_t v;
        v.name = nm; v.n = n; v.rst = rst; v.lk = lk;
        v.rb = rb; v.sr = sr; v.rdy = rdy; v.flt = flt; v.llc = llc;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic lk, input int n);
        for (int c = 0; c < n; c++) begin
            reset      = rst;
            pll_locked = lk;
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic rb, input logic sr, input logic rdy,
                         input logic flt, input logic [7:0] llc);
        n_vec++;
        if ({pll_resetb, sys_reset, ready, fault, lock_lost_count} !== {rb, sr, rdy, flt, llc}) begin
            n_bad++;
            $display("FAIL %s: got rb=%b sr=%b rdy=%b flt=%b llc=%0d, want rb=%b sr=%b rdy=%b flt=%b llc=%0d",
                     nm, pll_resetb, sys_reset, ready, fault, lock_lost_count,
                     rb, sr, rdy, flt, llc);
        end
    endtask

    task automatic run_table(input vec_t t[$]);
        foreach (t[i]) begin
            drive(t[i].rst, t[i].lk, t[i].n);
            check(t[i].name, t[i].rb, t[i].sr, t[i].rdy, t[i].flt, t[i].llc);
        end
    endtask

    initial begin
        // Clean bring-up (lock applied at cycle 10), then loss of lock in RUN
        //                name            n   rst lk  rb  sr  rdy flt llc
        tab1.push_back(mk("reset_state",   1, 1, 0, 0, 1, 0, 0, 8'd0));
        tab1.push_back(mk("t1_rst_low_e3", 3, 0, 0, 0, 1, 0, 0, 8'd0));
        tab1.push_back(mk("t1_rb_rise_e4", 1, 0, 0, 1, 1, 0, 0, 8'd0));
        tab1.push_back(mk("t1_wait_e9",    5, 0, 0, 1, 1, 0, 0, 8'd0));
        tab1.push_back(mk("t1_stable_e19",10, 0, 1, 1, 1, 0, 0, 8'd0));
        tab1.push_back(mk("t1_run_e20",    1, 0, 1, 1, 0, 1, 0, 8'd0));
        tab1.push_back(mk("t4_drop_e21",   1, 0, 0, 1, 0, 1, 0, 8'd0));
        tab1.push_back(mk("t4_drop_e22",   1, 0, 0, 1, 0, 1, 0, 8'd0));
        tab1.push_back(mk("t4_lost_e23",   1, 0, 0, 0, 1, 0, 0, 8'd1));
        tab1.push_back(mk("t4_prst_e26",   3, 0, 1, 0, 1, 0, 0, 8'd1));
        tab1.push_back(mk("t4_wait_e27",   1, 0, 1, 1, 1, 0, 0, 8'd1));
        tab1.push_back(mk("t4_stable_e35", 8, 0, 1, 1, 1, 0, 0, 8'd1));
        tab1.push_back(mk("t4_rerun_e36",  1, 0, 1, 1, 0, 1, 0, 8'd1));

        // Reset in RUN, STABLE glitch, lock-vs-timeout, retries/fault, reset in FAULT
        tab2.push_back(mk("t6_rst_in_run", 1, 1, 1, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t6_brup_e12",  12, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t6_brup_run",   1, 0, 1, 1, 0, 1, 0, 8'd0));
        tab2.push_back(mk("t2_reset",      1, 1, 1, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t2_stable_e7",  7, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t2_glitch_e8",  1, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t2_restart_e13",5, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t2_stable_e18", 5, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t2_run_e19",    1, 0, 1, 1, 0, 1, 0, 8'd0));
        tab2.push_back(mk("tw_reset",      1, 1, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("tw_wait_e21",  21, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("tw_lock_e23",   2, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("tw_lock_wins",  1, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("tw_stable_e31", 7, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("tw_run_e32",    1, 0, 1, 1, 0, 1, 0, 8'd0));
        tab2.push_back(mk("t3_reset",      1, 1, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_a_low_e3",   3, 0, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_a_high_e4",  1, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_a_high_e23",19, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_b_low_e24",  1, 0, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_b_low_e27",  3, 0, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_b_high_e28", 1, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_b_high_e47",19, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_c_low_e48",  1, 0, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_c_low_e51",  3, 0, 0, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_c_high_e52", 1, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_c_high_e71",19, 0, 0, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t3_fault_e72",  1, 0, 0, 0, 1, 0, 1, 8'd0));
        tab2.push_back(mk("t3_fault_hold",1000,0, 0, 0, 1, 0, 1, 8'd0));
        tab2.push_back(mk("t3_fault_lock",50, 0, 1, 0, 1, 0, 1, 8'd0));
        tab2.push_back(mk("t6_rst_in_flt", 1, 1, 1, 0, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t6_fbrup_e12", 12, 0, 1, 1, 1, 0, 0, 8'd0));
        tab2.push_back(mk("t6_fbrup_run",  1, 0, 1, 1, 0, 1, 0, 8'd0));

        repeat (3) @(posedge clock_in);
        #1;

        run_table(tab1);

        // Saturation: 260 lose/re-lock rounds starting from RUN with count 1.
        // Drop is seen on the 3rd edge; re-lock reaches RUN 13 edges later.
        for (int i = 0; i < 260; i++) begin
            logic [7:0] exp_llc;
            exp_llc = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
            drive(1'b0, 1'b0, 3);
            check("t5_lost", 1'b0, 1'b1, 1'b0, 1'b0, exp_llc);
            drive(1'b0, 1'b1, 13);
            check("t5_rerun", 1'b1, 1'b0, 1'b1, 1'b0, exp_llc);
        end

        run_table(tab2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Sequences bring-up of the iCE40 PLL that produces the 25 MHz VGA pixel clock.
- Runs on the 10 MHz reference clock and drives the PLL RESETB pin.
- Qualifies the PLL lock output, then releases a system reset for the pixel-clock domain.
- On loss of lock, retries PLL reset; after repeated failure it parks in a fault state.

Parameters:
RST_CYCLES, 16, cycles pll_resetb is held low per PLL reset attempt (min 1)
LOCK_TIMEOUT, 1000, cycles to wait for lock after releasing PLL reset (100 us @ 10 MHz)
STABLE_CYCLES, 64, consecutive cycles of lock required before release
MAX_RETRIES, 3, failed lock attempts tolerated before fault
CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clock_in  input  1  10 MHz reference clock; the single clock of this block
reset  input  1  synchronous, active-high reset
pll_locked  input  1  raw PLL LOCK output, asynchronous to clock_in
pll_resetb  output  1  to PLL RESETB; 0 = PLL held in reset
sys_reset  output  1  active-high reset for downstream logic; consumers resynchronise it into their own domain
ready  output  1  1 while the PLL is qualified and running
fault  output  1  1 once retries are exhausted; sticky until reset
lock_lost_count  output  8  saturating count of lock losses seen while running

Behaviour:
- Clocking and reset: one clock (clock_in); reset is synchronous and active-high.
- Reset values:
  - state = PLL_RST, counter = 0, retry_cnt = 0, lock_lost_count = 0.
  - Sync flops = 0, pll_resetb = 0, sys_reset = 1, ready = 0, fault = 0.
- Lock synchroniser: pll_locked passes through two flops to give lock_s (2-cycle latency). Only lock_s is used.
- Outputs are registered Moore decodes of state and change in the same edge as the state:
  - pll_resetb = 0 in PLL_RST and FAULT, else 1.
  - sys_reset = 0 only in RUN, else 1.
  - ready = (state == RUN).
  - fault = (state == FAULT).
- Counter: a single CNT_W counter, cleared on every state entry, incremented each cycle otherwise.
- PLL_RST: when counter == RST_CYCLES-1 -> WAIT_LOCK. pll_resetb is therefore low for exactly RST_CYCLES cycles after reset release.
- WAIT_LOCK:
  - lock_s = 1 -> STABLE.
  - Else if counter == LOCK_TIMEOUT-1: if retry_cnt == MAX_RETRIES -> FAULT; otherwise retry_cnt++ and -> PLL_RST.
  - If lock_s = 1 and the timeout occur in the same cycle, lock wins.
- STABLE:
  - lock_s = 0 -> WAIT_LOCK (counter cleared, retry_cnt unchanged).
  - counter == STABLE_CYCLES-1 with lock_s = 1 -> RUN and retry_cnt cleared.
- RUN: lock_s = 0 -> PLL_RST, lock_lost_count++ (saturates at 255). sys_reset rises on that same edge.
- FAULT: absorbing; exits only via reset.
- Reset mid-operation (any state): returns to PLL_RST with all reset values on the next edge. lock_lost_count is cleared too.
- Unreachable state encodings -> PLL_RST.

Decomposition:
- Shared package pll_sup_pkg:
  - State encoding constants PLL_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, FAULT = 4 (3-bit).
  - Default timing constants.
  - lock_lost_count width (8).
- One sub-module, sync_2ff: 2-flop single-bit synchroniser, synchronous active-high reset, reset value parameterised. Reused by VGA-domain consumers of sys_reset.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
1. Clean bring-up:
   - Stimulus: release reset at cycle 0; assert pll_locked at cycle 10 and hold.
   - Response: pll_resetb goes 0->1 at cycle 4. lock_s is seen at cycle 12. ready = 1 and sys_reset = 0 at cycle 20. lock_lost_count = 0.
2. Lock glitch during STABLE:
   - Stimulus: lock high for 5 cycles, low for 1, then high.
   - Response: state returns to WAIT_LOCK, ready stays 0, and the STABLE count restarts. RUN is reached 8 cycles after lock_s is re-seen. retry_cnt is unchanged.
3. Timeout and retry:
   - Stimulus: pll_locked held 0.
   - Response: pll_resetb low for 4 cycles, high for 20, repeated 3 times in total. FAULT is entered 20 cycles after the third release. fault = 1, pll_resetb = 0, sys_reset = 1, and these persist for 1000 further cycles.
4. Loss of lock in RUN:
   - Stimulus: reach RUN, then drop pll_locked.
   - Response: 2 cycles later sys_reset = 1, ready = 0, pll_resetb = 0, lock_lost_count = 1. Re-lock returns to RUN.
5. Counter saturation:
   - Stimulus: 260 lose/re-lock cycles.
   - Response: lock_lost_count = 255 and holds.
6. Reset mid-operation:
   - Stimulus: assert reset for 1 cycle while in FAULT, and separately while in RUN.
   - Response: next edge gives pll_resetb = 0, sys_reset = 1, fault = 0, lock_lost_count = 0. A normal bring-up follows.
